// File: rtl/kgp_pkg.sv
// kgp_pkg: shared datapath widths and ALU operation codes for the KGP-RISC execute stage
package kgp_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  typedef enum logic [3:0] {
    M_ADD, M_SUB, M_COMP, M_AND, M_OR, M_XOR, M_NOT, M_NOR,
    M_SHLL, M_SHRA, M_SHRL, M_SLT, M_SLTU, M_PASS1, M_PASS2, M_RSVD
  } alu_mode_e;
endpackage

// File: rtl/alu_register_bank_if.sv
// alu_register_bank_if: control, address, data and flag bundle of the execute-stage slice
interface alu_register_bank_if;
  import kgp_pkg::*;
  logic [ADDR_W-1:0] sr1, sr2, dr;
  logic write, sel, en;
  logic [DATA_W-1:0] wrData;
  alu_mode_e mode;
  logic [DATA_W-1:0] rData1, rData2, alu_out, wb_data;
  logic zero, carry;
  modport master (
    output sr1, sr2, dr, write, wrData, sel, en, mode,
    input rData1, rData2, alu_out, wb_data, zero, carry
  );
  modport slave (
    input sr1, sr2, dr, write, wrData, sel, en, mode,
    output rData1, rData2, alu_out, wb_data, zero, carry
  );
endinterface

// File: rtl/alu.sv
// alu: combinational 16-op ALU with zero and carry/borrow flags
module alu import kgp_pkg::*; (
  input  logic              en,
  input  alu_mode_e         mode,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry
);
  logic [DATA_W:0] sum, diff;
  logic [4:0] shamt;
  assign sum   = {1'b0, op1} + {1'b0, op2};
  assign diff  = {1'b0, op1} - {1'b0, op2};
  assign shamt = op2[4:0];
  always_comb begin
    result = '0;
    carry  = 1'b0;
    if (en)
      case (mode)
        M_ADD:   {carry, result} = sum;
        M_SUB:   {carry, result} = diff;
        M_COMP:  result = '0 - op2;
        M_AND:   result = op1 & op2;
        M_OR:    result = op1 | op2;
        M_XOR:   result = op1 ^ op2;
        M_NOT:   result = ~op1;
        M_NOR:   result = ~(op1 | op2);
        M_SHLL:  result = op1 << shamt;
        M_SHRA:  result = DATA_W'($signed(op1) >>> shamt);
        M_SHRL:  result = op1 >> shamt;
        M_SLT:   result = {{(DATA_W-1){1'b0}}, $signed(op1) < $signed(op2)};
        M_SLTU:  result = {{(DATA_W-1){1'b0}}, op1 < op2};
        M_PASS1: result = op1;
        M_PASS2: result = op2;
        default: result = '0;
      endcase
  end
  assign zero = result == '0;
endmodule

// File: rtl/mux.sv
// mux: 2:1 write-back select between ALU result and external data
module mux import kgp_pkg::*; (
  input  logic              sel,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/register_bank.sv
// register_bank: 32x32 storage, two asynchronous read ports, one synchronous write port, r0 tied to 0
module register_bank import kgp_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  input  logic [ADDR_W-1:0] dr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  logic [DATA_W-1:0] regs [2**ADDR_W];
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
    else if (write && dr != '0)
      regs[dr] <= wdata;
  // no write-to-read bypass: a same-cycle write becomes visible after the edge
  assign rdata1 = sr1 == '0 ? '0 : regs[sr1];
  assign rdata2 = sr2 == '0 ? '0 : regs[sr2];
endmodule

// File: rtl/alu_register_bank.sv
// alu_register_bank: execute-stage slice, register reads feed the ALU, write-back mux feeds the bank
module alu_register_bank import kgp_pkg::*; (
  input logic clk,
  input logic reset,
  alu_register_bank_if.slave bus
);
  register_bank u_bank (
    .clk    (clk),
    .reset  (reset),
    .write  (bus.write),
    .sr1    (bus.sr1),
    .sr2    (bus.sr2),
    .dr     (bus.dr),
    .wdata  (bus.wb_data),
    .rdata1 (bus.rData1),
    .rdata2 (bus.rData2)
  );
  alu u_alu (
    .en     (bus.en),
    .mode   (bus.mode),
    .op1    (bus.rData1),
    .op2    (bus.rData2),
    .result (bus.alu_out),
    .zero   (bus.zero),
    .carry  (bus.carry)
  );
  mux u_mux (
    .sel (bus.sel),
    .d0  (bus.alu_out),
    .d1  (bus.wrData),
    .y   (bus.wb_data)
  );
endmodule

// File: tb/tb_alu_register_bank.sv
// tb_alu_register_bank: directed scenarios plus randomized traffic against an array-based reference model
module tb_alu_register_bank;
  import kgp_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] m [32];
  alu_register_bank_if bus();
  alu_register_bank dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  function automatic logic [31:0] rd(input logic [4:0] a);
    return a == 0 ? 32'd0 : m[a];
  endfunction
  function automatic logic [32:0] ref_alu(input bit e, input int md, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    bit c;
    int sh;
    longint unsigned wide;
    r = 0;
    c = 0;
    sh = int'(b % 32);
    if (e)
      case (md)
        0: begin wide = longint'(a) + longint'(b); r = a + b; c = wide > 64'hFFFF_FFFF; end
        1: begin r = a - b; c = a < b; end
        2: r = 32'd0 - b;
        3: r = a & b;
        4: r = a | b;
        5: r = a ^ b;
        6: r = ~a;
        7: r = ~(a | b);
        8: r = a << sh;
        9: r = $signed(a) >>> sh;
        10: r = a >> sh;
        11: r = ($signed(a) < $signed(b)) ? 1 : 0;
        12: r = (a < b) ? 1 : 0;
        13: r = a;
        14: r = b;
        default: r = 0;
      endcase
    return {c, r};
  endfunction
  task automatic set(input int s1, input int s2, input int d, input bit w, input bit sl, input bit e, input int md, input logic [31:0] wd);
    bus.sr1 = 5'(s1);
    bus.sr2 = 5'(s2);
    bus.dr = 5'(d);
    bus.write = w;
    bus.sel = sl;
    bus.en = e;
    bus.mode = alu_mode_e'(4'(md));
    bus.wrData = wd;
  endtask
  task automatic tick();
    logic [32:0] a;
    logic [31:0] wb;
    a = ref_alu(bus.en, int'(bus.mode), rd(bus.sr1), rd(bus.sr2));
    wb = bus.sel ? bus.wrData : a[31:0];
    @(posedge clk);
    if (reset) for (int i = 0; i < 32; i++) m[i] = 0;
    else if (bus.write && bus.dr != 0) m[bus.dr] = wb;
    #2;
  endtask
  task automatic test_reset();
    set(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      bus.sr1 = 5'(i);
      #1;
      n_checks++;
      if (bus.rData1 !== 32'd0) begin n_fail++; $display("FAIL reset_clear r%0d: got %h want 0", i, bus.rData1); end
    end
    set(1, 0, 1, 1, 1, 0, 0, 32'h1234_5678);
    tick();
    #1;
    n_checks++;
    if (bus.rData1 !== 32'd0) begin n_fail++; $display("FAIL reset_beats_write: got %h want 0", bus.rData1); end
    reset = 1'b0;
  endtask
  task automatic test_write_read();
    set(1, 2, 1, 1, 1, 0, 0, 32'hFFFF_FE8E);
    tick();
    #1;
    n_checks++;
    if (bus.rData1 !== 32'hFFFF_FE8E) begin n_fail++; $display("FAIL write_r1: got %h want fffffe8e", bus.rData1); end
    set(1, 2, 2, 1, 1, 0, 0, 32'd1);
    #1;
    n_checks++;
    if (bus.rData2 !== 32'd0) begin n_fail++; $display("FAIL no_bypass_r2: got %h want 0", bus.rData2); end
    tick();
    #1;
    n_checks++;
    if (bus.rData2 !== 32'd1) begin n_fail++; $display("FAIL write_r2: got %h want 1", bus.rData2); end
  endtask
  task automatic test_alu_writeback();
    set(1, 2, 3, 1, 0, 1, 0, 32'h0);
    #1;
    n_checks++;
    if (bus.alu_out !== 32'hFFFF_FE8F || bus.wb_data !== 32'hFFFF_FE8F) begin
      n_fail++; $display("FAIL add_alu: alu_out %h wb_data %h want fffffe8f", bus.alu_out, bus.wb_data);
    end
    tick();
    bus.sr1 = 5'd3;
    bus.write = 1'b0;
    #1;
    n_checks++;
    if (bus.rData1 !== 32'hFFFF_FE8F) begin n_fail++; $display("FAIL add_writeback r3: got %h want fffffe8f", bus.rData1); end
    bus.en = 1'b0;
    #1;
    n_checks++;
    if (bus.alu_out !== 32'd0 || bus.zero !== 1'b1 || bus.carry !== 1'b0) begin
      n_fail++; $display("FAIL alu_disabled: alu_out %h zero %b carry %b want 0/1/0", bus.alu_out, bus.zero, bus.carry);
    end
  endtask
  task automatic test_shifts();
    int modes [3] = '{9, 10, 8};
    logic [31:0] exp [3] = '{32'hFFFF_FF47, 32'h7FFF_FF47, 32'hFFFF_FD1C};
    for (int k = 0; k < 3; k++) begin
      set(1, 2, 4, 1, 0, 1, modes[k], 32'h0);
      #1;
      n_checks++;
      if (bus.alu_out !== exp[k]) begin n_fail++; $display("FAIL shift_mode%0d alu: got %h want %h", modes[k], bus.alu_out, exp[k]); end
      tick();
      set(4, 2, 4, 0, 0, 1, modes[k], 32'h0);
      #1;
      n_checks++;
      if (bus.rData1 !== exp[k]) begin n_fail++; $display("FAIL shift_mode%0d r4: got %h want %h", modes[k], bus.rData1, exp[k]); end
    end
  endtask
  task automatic test_r0_hold();
    set(0, 0, 0, 1, 1, 0, 0, 32'hDEAD_BEEF);
    tick();
    #1;
    n_checks++;
    if (bus.rData1 !== 32'd0) begin n_fail++; $display("FAIL r0_write_ignored: got %h want 0", bus.rData1); end
    set(1, 0, 1, 0, 1, 0, 0, 32'hDEAD_BEEF);
    tick();
    #1;
    n_checks++;
    if (bus.rData1 !== 32'hFFFF_FE8E) begin n_fail++; $display("FAIL hold_write0 r1: got %h want fffffe8e", bus.rData1); end
  endtask
  task automatic test_flags();
    set(0, 2, 0, 0, 0, 1, 1, 32'h0);
    #1;
    n_checks++;
    if (bus.alu_out !== 32'hFFFF_FFFF || bus.carry !== 1'b1 || bus.zero !== 1'b0) begin
      n_fail++; $display("FAIL sub_borrow: alu_out %h carry %b zero %b want ffffffff/1/0", bus.alu_out, bus.carry, bus.zero);
    end
    set(0, 2, 5, 1, 1, 0, 0, 32'hFFFF_FFFF);
    tick();
    set(5, 2, 0, 0, 0, 1, 0, 32'h0);
    #1;
    n_checks++;
    if (bus.alu_out !== 32'd0 || bus.carry !== 1'b1 || bus.zero !== 1'b1) begin
      n_fail++; $display("FAIL add_overflow: alu_out %h carry %b zero %b want 0/1/1", bus.alu_out, bus.carry, bus.zero);
    end
    set(1, 2, 0, 0, 0, 1, 11, 32'h0);
    #1;
    n_checks++;
    if (bus.alu_out !== 32'd1) begin n_fail++; $display("FAIL slt: got %h want 1", bus.alu_out); end
    bus.mode = M_SLTU;
    #1;
    n_checks++;
    if (bus.alu_out !== 32'd0) begin n_fail++; $display("FAIL sltu: got %h want 0", bus.alu_out); end
  endtask
  task automatic test_random();
    logic [32:0] a;
    logic [31:0] wb;
    for (int n = 0; n < 400; n++) begin
      set($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom), 1'($urandom),
          $urandom_range(0, 7) != 0, $urandom_range(0, 15), ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      reset = $urandom_range(0, 79) == 0;
      #1;
      a = ref_alu(bus.en, int'(bus.mode), rd(bus.sr1), rd(bus.sr2));
      wb = bus.sel ? bus.wrData : a[31:0];
      n_checks++;
      if (bus.rData1 !== rd(bus.sr1) || bus.rData2 !== rd(bus.sr2)) begin
        n_fail++; $display("FAIL rand_read #%0d: rData1 %h rData2 %h want %h %h", n, bus.rData1, bus.rData2, rd(bus.sr1), rd(bus.sr2));
      end
      n_checks++;
      if (bus.alu_out !== a[31:0] || bus.carry !== a[32] || bus.zero !== (a[31:0] == 0)) begin
        n_fail++; $display("FAIL rand_alu #%0d mode %0d: alu_out %h carry %b zero %b want %h %b %b", n, int'(bus.mode),
                           bus.alu_out, bus.carry, bus.zero, a[31:0], a[32], a[31:0] == 0);
      end
      n_checks++;
      if (bus.wb_data !== wb) begin n_fail++; $display("FAIL rand_wb #%0d: got %h want %h", n, bus.wb_data, wb); end
      tick();
    end
    reset = 1'b0;
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_alu_writeback();
    test_shifts();
    test_r0_hold();
    test_flags();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
